// File: rtl/ex_stage_exec.sv
// Execute stage: single-cycle ALU plus iterative radix-2 MUL/DIV/REM behind valid/ready handshakes.
// Optional EX_PERF_CNT_EN adds a saturating stall_cycles counter output.
module ex_stage_exec #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode_in,
  input  logic [DATA_W-1:0] rs_data_in,
  input  logic [DATA_W-1:0] rt_data_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              illegal_out,
`ifdef EX_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h05;
  localparam logic [5:0] OP_MUL  = 6'h10;
  localparam logic [5:0] OP_DIV  = 6'h11;
  localparam logic [5:0] OP_REM  = 6'h12;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

  state_t            state;
  kind_t             kind;
  kind_t             new_kind;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [REG_AW-1:0] multi_rd;

  logic              accept;
  logic              is_nop;
  logic              is_multi;
  logic              alu_illegal;
  logic [DATA_W-1:0] alu_result;

  logic [DATA_W-1:0] mul_acc_next;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem_next;
  logic [DATA_W-1:0] div_quot_next;
  logic [DATA_W-1:0] step_result;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == BUSY);

  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    is_nop      = 1'b0;
    is_multi    = 1'b0;
    new_kind    = K_MUL;
    case (opcode_in)
      OP_NOP:  is_nop = 1'b1;
      OP_ADD:  alu_result = rs_data_in + rt_data_in;
      OP_SUB:  alu_result = rs_data_in - rt_data_in;
      OP_AND:  alu_result = rs_data_in & rt_data_in;
      OP_OR:   alu_result = rs_data_in | rt_data_in;
      OP_ADDI: alu_result = rs_data_in + imm_in;
      OP_MUL:  is_multi = 1'b1;
      OP_DIV: begin
        is_multi = 1'b1;
        new_kind = K_DIV;
      end
      OP_REM: begin
        is_multi = 1'b1;
        new_kind = K_REM;
      end
      default: alu_illegal = 1'b1;
    endcase
  end

  // acc is the product for MUL and the partial remainder for DIV/REM; op_a shifts the
  // multiplicand left or the dividend out / quotient in. A zero divisor naturally yields
  // all-ones quotient and remainder equal to the dividend.
  always_comb begin
    mul_acc_next  = acc + (op_b[0] ? op_a : '0);
    div_shift     = {acc, op_a[DATA_W-1]};
    div_diff      = div_shift - {1'b0, op_b};
    div_ge        = !div_diff[DATA_W];
    div_rem_next  = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    div_quot_next = {op_a[DATA_W-2:0], div_ge};
    case (kind)
      K_DIV:   step_result = div_quot_next;
      K_REM:   step_result = div_rem_next;
      default: step_result = mul_acc_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      kind        <= K_MUL;
      count       <= '0;
      acc         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      multi_rd    <= '0;
      out_valid   <= 1'b0;
      result_out  <= '0;
      rd_out      <= '0;
      illegal_out <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_multi) begin
            state    <= BUSY;
            kind     <= new_kind;
            count    <= '0;
            acc      <= '0;
            op_a     <= rs_data_in;
            op_b     <= rt_data_in;
            multi_rd <= rd_in;
          end else if (accept && !is_nop) begin
            result_out  <= alu_result;
            rd_out      <= rd_in;
            illegal_out <= alu_illegal;
            out_valid   <= 1'b1;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
            if (kind == K_MUL) begin
              acc  <= mul_acc_next;
              op_a <= op_a << 1;
              op_b <= op_b >> 1;
            end else begin
              acc  <= div_rem_next;
              op_a <= div_quot_next;
            end
            // Output register is empty here: entry to BUSY required it empty or draining.
            if (count == LAST_STEP) begin
              state       <= IDLE;
              result_out  <= step_result;
              rd_out      <= multi_rd;
              illegal_out <= 1'b0;
              out_valid   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      stall_cycles <= '0;
    else if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ex_stage_exec.sv
// Self-checking bench for ex_stage_exec: table-driven ALU vectors plus directed multi-cycle sequences.
module tb_ex_stage_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode_in;
  logic [31:0] rs_data_in;
  logic [31:0] rt_data_in;
  logic [4:0]  rd_in;
  logic [31:0] imm_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_out;
  logic [4:0]  rd_out;
  logic        illegal_out;
  logic        busy;
`ifdef EX_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int nChecks = 0;
  int nErrors = 0;

  ex_stage_exec #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opcode_in(opcode_in),
    .rs_data_in(rs_data_in),
    .rt_data_in(rt_data_in),
    .rd_in(rd_in),
    .imm_in(imm_in),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result_out(result_out),
    .rd_out(rd_out),
    .illegal_out(illegal_out),
`ifdef EX_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        expValid;
    logic [31:0] expResult;
    logic        expIllegal;
  } alu_vec_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [31:0] expResult;
  } multi_vec_t;

  alu_vec_t   aluVecs[10];
  multi_vec_t multiVecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [5:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] rd);
    in_valid   = valid;
    opcode_in  = op;
    rs_data_in = rs;
    rt_data_in = rt;
    imm_in     = imm;
    rd_in      = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one multi-cycle op and expects its result exactly 32 cycles after acceptance.
  task automatic runMulti(input multi_vec_t v);
    int   n;
    logic sawReady;
    applyStimulus(1'b1, v.op, v.rs, v.rt, 32'h0, v.rd);
    checkOutput({v.name, " in_ready before issue"}, 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0);
    checkOutput({v.name, " busy"}, 32'(busy), 32'd1);
    n = 0;
    sawReady = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) sawReady = 1'b1;
      tick();
      n++;
    end
    checkOutput({v.name, " latency"}, 32'(n), 32'd32);
    checkOutput({v.name, " in_ready while busy"}, 32'(sawReady), 32'd0);
    checkOutput({v.name, " result"}, result_out, v.expResult);
    checkOutput({v.name, " rd"}, 32'(rd_out), 32'(v.rd));
    checkOutput({v.name, " illegal"}, 32'(illegal_out), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    logic sawValid;

    aluVecs[0] = '{"ADD wrap",   6'h01, 32'hFFFF_FFFF, 32'h1,      32'h0,         5'd3,  1'b1, 32'h0,         1'b0};
    aluVecs[1] = '{"ADDI neg",   6'h05, 32'h5,         32'h0,      32'hFFFF_FFFE, 5'd4,  1'b1, 32'h3,         1'b0};
    aluVecs[2] = '{"SUB",        6'h02, 32'd10,        32'd3,      32'h0,         5'd5,  1'b1, 32'd7,         1'b0};
    aluVecs[3] = '{"SUB wrap",   6'h02, 32'd0,         32'd1,      32'h0,         5'd6,  1'b1, 32'hFFFF_FFFF, 1'b0};
    aluVecs[4] = '{"AND",        6'h03, 32'h0000_F0F0, 32'h0000_FF00, 32'h0,      5'd8,  1'b1, 32'h0000_F000, 1'b0};
    aluVecs[5] = '{"OR",         6'h04, 32'h0000_0F0F, 32'h0000_F000, 32'h0,      5'd9,  1'b1, 32'h0000_FF0F, 1'b0};
    aluVecs[6] = '{"NOP",        6'h00, 32'h1234,      32'h5678,   32'h0,         5'd10, 1'b0, 32'h0,         1'b0};
    aluVecs[7] = '{"ILLEGAL 3F", 6'h3F, 32'h1234,      32'h5678,   32'h0,         5'd11, 1'b1, 32'h0,         1'b1};
    aluVecs[8] = '{"ILLEGAL 06", 6'h06, 32'hFFFF,      32'h1,      32'h0,         5'd12, 1'b1, 32'h0,         1'b1};
    aluVecs[9] = '{"ADD rd0",    6'h01, 32'd20,        32'd22,     32'h0,         5'd0,  1'b1, 32'd42,        1'b0};

    multiVecs[0] = '{"MUL",       6'h10, 32'h0001_0000, 32'h0001_0001, 5'd7,  32'h0001_0000};
    multiVecs[1] = '{"MUL max",   6'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001};
    multiVecs[2] = '{"DIV",       6'h11, 32'd100,       32'd7,         5'd14, 32'd14};
    multiVecs[3] = '{"REM",       6'h12, 32'd100,       32'd7,         5'd15, 32'd2};
    multiVecs[4] = '{"DIV by 0",  6'h11, 32'd123,       32'd0,         5'd16, 32'hFFFF_FFFF};
    multiVecs[5] = '{"REM by 0",  6'h12, 32'd9,         32'd0,         5'd17, 32'd9};

    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", result_out, 32'h0);
    checkOutput("reset rd", 32'(rd_out), 32'h0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);

    // Back-to-back single-cycle ops with out_ready held high: one result per cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, aluVecs[i].op, aluVecs[i].rs, aluVecs[i].rt, aluVecs[i].imm, aluVecs[i].rd);
      checkOutput({aluVecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
      tick();
      checkOutput({aluVecs[i].name, " valid"}, 32'(out_valid), 32'(aluVecs[i].expValid));
      if (aluVecs[i].expValid) begin
        checkOutput({aluVecs[i].name, " result"}, result_out, aluVecs[i].expResult);
        checkOutput({aluVecs[i].name, " rd"}, 32'(rd_out), 32'(aluVecs[i].rd));
        checkOutput({aluVecs[i].name, " illegal"}, 32'(illegal_out), 32'(aluVecs[i].expIllegal));
      end
    end

    for (int i = 0; i < 6; i++) runMulti(multiVecs[i]);

    // Output back-pressure: result held, no acceptance, then drain and accept on one edge.
    applyStimulus(1'b1, 6'h02, 32'd10, 32'd3, 32'h0, 5'd2);
    tick();
    out_ready = 1'b0;
    applyStimulus(1'b1, 6'h01, 32'd1, 32'd1, 32'h0, 5'd9);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall valid", 32'(out_valid), 32'd1);
      checkOutput("stall result", result_out, 32'd7);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    checkOutput("stall result after", result_out, 32'd7);
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0);
    checkOutput("release valid", 32'(out_valid), 32'd1);
    checkOutput("release result", result_out, 32'd2);
    checkOutput("release rd", 32'(rd_out), 32'd9);
    tick();
    checkOutput("drained valid", 32'(out_valid), 32'd0);

    // Flush at BUSY cycle 10 discards the divide.
    applyStimulus(1'b1, 6'h11, 32'd100, 32'd7, 32'h0, 5'd1);
    tick();
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush valid", 32'(out_valid), 32'd0);
    checkOutput("flush busy", 32'(busy), 32'd0);
    checkOutput("flush in_ready", 32'(in_ready), 32'd1);
    sawValid = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (out_valid) sawValid = 1'b1;
      tick();
    end
    checkOutput("flush no late result", 32'(sawValid), 32'd0);

    // Flush in IDLE blocks acceptance.
    flush = 1'b1;
    applyStimulus(1'b1, 6'h01, 32'd3, 32'd4, 32'h0, 5'd5);
    #1;
    checkOutput("idle flush in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0);
    checkOutput("idle flush valid", 32'(out_valid), 32'd0);

    // Flush on the completion edge wins.
    applyStimulus(1'b1, 6'h10, 32'd6, 32'd7, 32'h0, 5'd6);
    tick();
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 31; i++) tick();
    checkOutput("pre-complete busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checkOutput("complete flush valid", 32'(out_valid), 32'd0);
    checkOutput("complete flush busy", 32'(busy), 32'd0);

    // Reset mid-BUSY abandons the op.
    applyStimulus(1'b1, 6'h10, 32'd6, 32'd7, 32'h0, 5'd6);
    tick();
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("midbusy reset busy", 32'(busy), 32'd0);
    checkOutput("midbusy reset result", result_out, 32'h0);
    n = 0;
    sawValid = 1'b0;
    while (n < 35) begin
      if (out_valid) sawValid = 1'b1;
      tick();
      n++;
    end
    checkOutput("midbusy reset no result", 32'(sawValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/ex_stage_exec.md
Name: ex_stage_exec

Overview:
- Execute-stage consumer of the ID/EX pipeline register outputs (opcode, rs/rt data, rd, imm).
- Performs single-cycle ALU ops and iterative multi-cycle MUL/DIV/REM.
- Back-pressures decode through a valid/ready handshake, so in_ready low is the ID-stage stall.
- Delivers a registered result plus destination register to the EX/MEM side through a second valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width; MUL/DIV iteration count equals DATA_W.
- REG_AW, 5, destination register index width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous active-low reset (asserted when 0).
- in_valid  input  1  ID/EX register holds a valid instruction.
- in_ready  output  1  EX accepts this cycle; the ID stage stalls when low.
- opcode_in  input  6  operation code.
- rs_data_in  input  DATA_W  operand A.
- rt_data_in  input  DATA_W  operand B.
- rd_in  input  REG_AW  destination register.
- imm_in  input  DATA_W  sign-extended immediate.
- flush  input  1  kill any in-flight multi-cycle op.
- out_valid  output  1  result register valid.
- out_ready  input  1  EX/MEM side accepts the result.
- result_out  output  DATA_W  computed result.
- rd_out  output  REG_AW  destination of result.
- illegal_out  output  1  result came from an undefined opcode.
- busy  output  1  multi-cycle op in progress.

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, out_valid=0, result_out=0, rd_out=0, illegal_out=0, iteration counter=0, busy=0. Reset mid-BUSY abandons the op with no output.
- Opcodes:
  - 00 NOP: accepted, produces no output.
  - 01 ADD: rs+rt.
  - 02 SUB: rs-rt.
  - 03 AND.
  - 04 OR.
  - 05 ADDI: rs+imm.
  - 10 MUL: low DATA_W bits of unsigned rs*rt.
  - 11 DIV: unsigned rs/rt.
  - 12 REM: unsigned rs%rt.
  - Any other opcode: result 0, illegal_out=1, single-cycle.
- Arithmetic wraps modulo 2^DATA_W; no overflow flag.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Transfer occurs when in_valid && in_ready.
- Output handshake: the result transfers when out_valid && out_ready. Afterwards out_valid clears unless a new result is loaded on the same edge. result_out, rd_out and illegal_out hold stable while out_valid && !out_ready.
- FSM IDLE:
  - Accepted ALU or illegal op: result/rd/illegal loaded at that edge, out_valid=1 the next cycle (latency 1). Back-to-back throughput is 1/cycle while out_ready=1.
  - Accepted MUL/DIV/REM: latch operands and rd, counter=0, go to BUSY.
  - Accepted NOP: stay IDLE, out_valid unchanged apart from any drain.
- FSM BUSY:
  - busy=1, in_ready=0.
  - One radix-2 step per cycle: shift-add for MUL, restoring shift-subtract for DIV/REM. Counter increments.
  - On the edge where the counter reaches DATA_W-1: load result, out_valid=1, go to IDLE. First result is visible DATA_W cycles after acceptance.
  - The output register is guaranteed empty on entry to BUSY, because acceptance required it empty or draining.
- flush:
  - In BUSY: at the next edge return to IDLE, discard the op, out_valid unaffected.
  - In IDLE: blocks acceptance that cycle.
  - flush on the same edge as BUSY completion: flush wins, no result.
- Divide by zero (rt==0): DIV returns all ones; REM returns rs. Both still take DATA_W cycles.
- rd==0 results are still delivered; suppression is downstream's job.

Optional Feature:
- EX_PERF_CNT_EN: adds output stall_cycles (32 bits). It increments every cycle that in_valid && !in_ready, saturates at 0xFFFFFFFF, and clears on reset.
- Without the macro: the port and counter are absent and the remaining behaviour is identical.

Test Plan:
- Reset low 2 cycles, then high -> out_valid=0, result_out=0, in_ready=1, busy=0.
- ADD rs=0xFFFFFFFF rt=1 rd=3, out_ready=1 -> next cycle out_valid=1, result_out=0, rd_out=3. Follow with ADDI rs=5 imm=0xFFFFFFFE back-to-back -> result 3 the cycle after, no bubble.
- MUL rs=0x10000 rt=0x10001 rd=7 -> in_ready=0 for 32 cycles; out_valid after 32 cycles with result 0x00010000 (low 32 bits of 0x100010000), rd_out=7.
- DIV rs=100 rt=7 -> result 14; REM same operands -> 2; DIV rt=0 -> 0xFFFFFFFF; REM rs=9 rt=0 -> 9.
- out_ready=0 for 5 cycles after an SUB 10-3 result -> result_out stays 7 and in_ready=0. Release -> transfer, and a new op is accepted on the same edge.
- Issue DIV, assert flush at BUSY cycle 10 -> no out_valid, in_ready=1 next cycle. Opcode 0x3F -> illegal_out=1, result 0.
